// File: rtl/ncl_result_checker_if.sv
// ---------------------------------------------------------------------------
// ncl_result_checker_if
// Groups the checker's request/stimulus inputs and result outputs so that the
// checker and whatever drives it share one bundle.
//
// Signals
//   start          one-cycle request to begin a check run
//   gnt            stimulus generator end-of-sequence indication
//   stm_value      stimulus currently applied to both gates
//   y_ref, y       reference gate output / gate-under-test output
//   busy, done     run in progress / run finished
//   pass           run finished with no mismatch and no counter overflow
//   vec_cnt        number of compared cycles
//   err_cnt        number of mismatching cycles
//   ovf            sticky counter-overflow flag
//   err_pulse      one cycle after each mismatch
//   first_err_*    capture of the first mismatch (valid, stimulus, index)
//
// Modports: master drives the stimulus side, slave is the checker.
// ---------------------------------------------------------------------------
interface ncl_result_checker_if #(
  parameter int INPUT_PORTS = 3,
  parameter int CNT_W       = 16
);
  logic                   start;
  logic                   gnt;
  logic [INPUT_PORTS-1:0] stm_value;
  logic                   y_ref;
  logic                   y;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [CNT_W-1:0]       vec_cnt;
  logic [CNT_W-1:0]       err_cnt;
  logic                   ovf;
  logic                   err_pulse;
  logic                   first_err_vld;
  logic [INPUT_PORTS-1:0] first_err_stm;
  logic [CNT_W-1:0]       first_err_idx;

  modport master (
    output start, gnt, stm_value, y_ref, y,
    input  busy, done, pass, vec_cnt, err_cnt, ovf, err_pulse,
           first_err_vld, first_err_stm, first_err_idx
  );

  modport slave (
    input  start, gnt, stm_value, y_ref, y,
    output busy, done, pass, vec_cnt, err_cnt, ovf, err_pulse,
           first_err_vld, first_err_stm, first_err_idx
  );
endinterface

// File: rtl/ncl_result_checker.sv
// ---------------------------------------------------------------------------
// ncl_result_checker
// Compares a gate-under-test output against a reference gate output every
// cycle of a check run, counting compared cycles and mismatches, and records
// the stimulus and index of the first mismatch.
//
// Run sequence: IDLE --start--> RUN --gnt--> DRAIN (DRAIN_CYC cycles) --> DONE.
// RUN and DRAIN cycles are compare cycles; DONE holds results until the next
// start.
//
// Ports
//   clk   rising-edge clock
//   rsb   asynchronous active-low reset
//   bus   ncl_result_checker_if.slave (stimulus in, results out)
// ---------------------------------------------------------------------------
module ncl_result_checker #(
  parameter int INPUT_PORTS = 3,
  parameter int CNT_W       = 16,
  parameter int DRAIN_CYC   = 2
) (
  input logic                 clk,
  input logic                 rsb,
  ncl_result_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  state_t                 r_state;
  logic [DRAIN_W-1:0]     r_drain_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic [CNT_W-1:0]       r_vec_cnt;
  logic [CNT_W-1:0]       r_err_cnt;
  logic                   r_ovf;
  logic                   r_err_pulse;
  logic                   r_first_err_vld;
  logic [INPUT_PORTS-1:0] r_first_err_stm;
  logic [CNT_W-1:0]       r_first_err_idx;

  logic w_cmp;
  logic w_mis;
  logic w_vec_full;
  logic w_err_full;
  logic w_ovf_next;
  logic w_err_zero_next;

  // Case-inequality so that X or Z on either gate output counts as a mismatch.
  // The ovf/err "next" values let pass be decided on the same edge that
  // retires the final compare cycle.
  assign w_cmp           = (r_state == RUN) || (r_state == DRAIN);
  assign w_mis           = w_cmp && (bus.y !== bus.y_ref);
  assign w_vec_full      = &r_vec_cnt;
  assign w_err_full      = &r_err_cnt;
  assign w_ovf_next      = r_ovf | (w_cmp & w_vec_full) | (w_mis & w_err_full);
  assign w_err_zero_next = (r_err_cnt == '0) && !w_mis;

  // Single FSM block: state, counters, first-error capture and all outputs.
  // Counters saturate; a blocked increment raises the sticky ovf flag.
  always_ff @(posedge clk or negedge rsb) begin
    if (!rsb) begin
      r_state         <= IDLE;
      r_drain_cnt     <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_vec_cnt       <= '0;
      r_err_cnt       <= '0;
      r_ovf           <= 1'b0;
      r_err_pulse     <= 1'b0;
      r_first_err_vld <= 1'b0;
      r_first_err_stm <= '0;
      r_first_err_idx <= '0;
    end else begin
      r_err_pulse <= w_mis;

      if (w_cmp) begin
        r_ovf <= w_ovf_next;
        if (!w_vec_full) begin
          r_vec_cnt <= r_vec_cnt + CNT_ONE;
        end
        if (w_mis && !w_err_full) begin
          r_err_cnt <= r_err_cnt + CNT_ONE;
        end
        // Index is the pre-increment vec_cnt of the first failing compare.
        if (w_mis && !r_first_err_vld) begin
          r_first_err_vld <= 1'b1;
          r_first_err_stm <= bus.stm_value;
          r_first_err_idx <= r_vec_cnt;
        end
      end

      case (r_state)
        IDLE, DONE: begin
          // gnt is deliberately ignored here, even when it arrives with start.
          if (bus.start) begin
            r_state         <= RUN;
            r_drain_cnt     <= '0;
            r_vec_cnt       <= '0;
            r_err_cnt       <= '0;
            r_ovf           <= 1'b0;
            r_first_err_vld <= 1'b0;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
          end
        end
        RUN: begin
          if (bus.gnt) begin
            if (DRAIN_CYC == 0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_err_zero_next && !w_ovf_next;
            end else begin
              r_state     <= DRAIN;
              r_drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_err_zero_next && !w_ovf_next;
          end else begin
            r_drain_cnt <= r_drain_cnt + DRAIN_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.pass          = r_pass;
  assign bus.vec_cnt       = r_vec_cnt;
  assign bus.err_cnt       = r_err_cnt;
  assign bus.ovf           = r_ovf;
  assign bus.err_pulse     = r_err_pulse;
  assign bus.first_err_vld = r_first_err_vld;
  assign bus.first_err_stm = r_first_err_stm;
  assign bus.first_err_idx = r_first_err_idx;

endmodule

// File: doc/ncl_result_checker.md
NCL_RESULT_CHECKER -- requirements
Module: ncl_result_checker

Interface
REQ-001: Parameter INPUT_PORTS, default 3, width of the stimulus vector applied to the gate under test.
REQ-002: Parameter CNT_W, default 16, width of the vector and error counters.
REQ-003: Parameter DRAIN_CYC, default 2, number of post-gnt cycles still compared.
REQ-004: clk  input  1  single clock, rising edge active.
REQ-005: rsb  input  1  reset, asynchronous, active-low.
REQ-006: start  input  1  one-cycle request to begin a check run; same meaning as the bench req.
REQ-007: gnt  input  1  stimulus generator end-of-sequence indication.
REQ-008: stm_value  input  INPUT_PORTS  stimulus currently applied to both gates.
REQ-009: y_ref  input  1  reference gate output.
REQ-010: y  input  1  gate-under-test output.
REQ-011: busy  output  1  high in RUN or DRAIN.
REQ-012: done  output  1  high in DONE.
REQ-013: pass  output  1  high in DONE when err_cnt==0 and ovf==0.
REQ-014: vec_cnt  output  CNT_W  number of compared cycles.
REQ-015: err_cnt  output  CNT_W  number of mismatching cycles.
REQ-016: ovf  output  1  sticky flag: a counter attempted to increment past all-ones.
REQ-017: err_pulse  output  1  registered, high for one cycle after each mismatch.
REQ-018: first_err_vld  output  1  sticky flag: first_err_* captured.
REQ-019: first_err_stm  output  INPUT_PORTS  stm_value at the first mismatch.
REQ-020: first_err_idx  output  CNT_W  vec_cnt value at the first mismatch.

Function
REQ-021: The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-022: IDLE: start=1 -> RUN next edge; start SHALL clear the counters, ovf, first_err_vld, and drain counter on that edge.
REQ-023: RUN: every cycle is a compare cycle; gnt=1 -> DRAIN; start SHALL be ignored.
REQ-024: DRAIN: every cycle is a compare cycle; after exactly DRAIN_CYC cycles -> DONE; DRAIN_CYC=0 SHALL go RUN -> DONE directly on gnt.
REQ-025: DONE: outputs held; start=1 -> RUN with the same clearing as REQ-022; gnt ignored.
REQ-026: Compare cycle: vec_cnt += 1; mismatch defined as case-inequality of y and y_ref (X or Z on either counts as a mismatch); on mismatch err_cnt += 1 and err_pulse=1 next cycle.
REQ-027: The cycle in which gnt is sampled in RUN SHALL itself be compared.
REQ-028: First mismatch while first_err_vld=0 SHALL capture stm_value and the pre-increment vec_cnt, then set first_err_vld; later mismatches SHALL NOT overwrite it.
REQ-029: Counters SHALL saturate at 2^CNT_W-1; a blocked increment SHALL set ovf.
REQ-030: start and gnt together in IDLE SHALL enter RUN; gnt SHALL be ignored that cycle.
REQ-031: The compare-to-counter latency SHALL be one cycle; all outputs SHALL be registered.

Reset
REQ-032: rsb=0 SHALL asynchronously force IDLE, all counters 0, and busy, done, pass, ovf, err_pulse, first_err_vld, first_err_stm, first_err_idx to 0, including during RUN or DRAIN.
REQ-033: After rsb deasserts, the block SHALL remain in IDLE until start is sampled.

Verification
REQ-034: start; 8 cycles y=y_ref; gnt; DRAIN_CYC=2 -> done=1, pass=1, vec_cnt=11, err_cnt=0.
REQ-035: Mismatch at compare 3 (stm_value=3'b101) and compare 6 -> err_cnt=2, first_err_stm=3'b101, first_err_idx=3, pass=0, two err_pulse pulses.
REQ-036: y=1'bx, y_ref=1 on one compare cycle -> err_cnt=1.
REQ-037: CNT_W=4, 20 compare cycles -> vec_cnt=15, ovf=1, pass=0.
REQ-038: rsb low mid-RUN -> all outputs 0 immediately; start and gnt in the same cycle from IDLE -> RUN, not DONE.
REQ-039: start in DONE -> counters cleared, busy=1 next cycle.
